// File: rtl/pc_unit.sv
// pc_unit: MIPS fetch-stage program counter with stall, redirect, trap and fetch handshake
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter int               STEP         = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0180),
   parameter int               REGION_BITS  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_stall,
   input  logic                   i_fetch_ready,
   input  logic                   i_redirect_valid,
   input  logic [WIDTH-1:0]       i_redirect_pc,
   input  logic                   i_trap,
   output logic                   o_fetch_valid,
   output logic [WIDTH-1:0]       o_pc_out,
   output logic [WIDTH-1:0]       o_pc_plus,
   output logic [REGION_BITS-1:0] o_pc_region,
   output logic                   o_redirect_pending
);
   typedef enum logic {BOOT, RUN} state_t;
   // Clears the low log2(STEP) bits so redirect targets are always step-aligned
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(STEP) - WIDTH'(1));
   state_t           r_state;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_pend_pc;
   logic             r_pending;
   logic             r_fetch_valid;
   logic             w_advance;
   logic [WIDTH-1:0] w_redir;
   // Advance qualifier and aligned redirect target
   always_comb begin
      w_advance = i_fetch_ready & ~i_stall;
      w_redir   = i_redirect_pc & ALIGN_MASK;
   end
   // Boot/run FSM holding the PC and the pending redirect; trap outranks advance, live redirect outranks pending
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= BOOT;
         r_pc          <= RESET_VECTOR;
         r_pend_pc     <= '0;
         r_pending     <= 1'b0;
         r_fetch_valid <= 1'b0;
      end else begin
         case (r_state)
            BOOT: begin
               r_state       <= RUN;
               r_fetch_valid <= 1'b1;
            end
            default: begin
               if (i_trap) begin
                  r_pc      <= TRAP_VECTOR;
                  r_pending <= 1'b0;
               end else if (w_advance) begin
                  r_pc      <= i_redirect_valid ? w_redir : r_pending ? r_pend_pc : r_pc + WIDTH'(STEP);
                  r_pending <= 1'b0;
               end else if (i_redirect_valid) begin
                  r_pend_pc <= w_redir;
                  r_pending <= 1'b1;
               end
            end
         endcase
      end
   end
   // Derived outputs are combinational from the registered PC
   always_comb begin
      o_fetch_valid      = r_fetch_valid;
      o_pc_out           = r_pc;
      o_pc_plus          = r_pc + WIDTH'(STEP);
      o_pc_region        = r_pc[WIDTH-1 -: REGION_BITS];
      o_redirect_pending = r_pending;
   end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized and directed checks of pc_unit against a behavioural fetch model
module tb_pc_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, ready = 1'b0, rv = 1'b0, trap = 1'b0;
   logic [31:0] rpc = '0;
   logic        fv, pend;
   logic [31:0] pc, pcp;
   logic [3:0]  reg4;
   logic        w_fv, w_pend;
   logic [7:0]  w_pc, w_pcp;
   logic [3:0]  w_reg;
   int          checks = 0, failures = 0;
   // Behavioural model state
   bit          m_run;
   logic [31:0] m_pc;
   bit          m_pend;
   logic [31:0] m_pend_pc;

   always #5 clk = ~clk;

   pc_unit dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_fetch_ready(ready),
      .i_redirect_valid(rv), .i_redirect_pc(rpc), .i_trap(trap),
      .o_fetch_valid(fv), .o_pc_out(pc), .o_pc_plus(pcp), .o_pc_region(reg4),
      .o_redirect_pending(pend)
   );

   pc_unit #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h80), .REGION_BITS(4)) dut_w (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(1'b0), .i_fetch_ready(1'b1),
      .i_redirect_valid(1'b0), .i_redirect_pc(8'h00), .i_trap(1'b0),
      .o_fetch_valid(w_fv), .o_pc_out(w_pc), .o_pc_plus(w_pcp), .o_pc_region(w_reg),
      .o_redirect_pending(w_pend)
   );

   task automatic model_reset();
      m_run = 0; m_pc = 32'h0; m_pend = 0; m_pend_pc = '0;
   endtask

   // One clock: apply the fetch rules to the model, then move to just after the edge
   task automatic tick();
      logic [31:0] tgt;
      tgt = {rpc[31:2], 2'b00};
      if (!m_run) m_run = 1;
      else if (trap) begin m_pc = 32'h180; m_pend = 0; end
      else if (ready && !stall) begin
         if (rv) m_pc = tgt;
         else if (m_pend) m_pc = m_pend_pc;
         else m_pc = m_pc + 32'd4;
         m_pend = 0;
      end else if (rv) begin m_pend = 1; m_pend_pc = tgt; end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 0; model_reset(); #1;
      checks++; if (pc !== 32'h0 || fv !== 1'b0 || pend !== 1'b0) begin failures++; $display("FAIL reset_state pc=%h fv=%b pend=%b want 0/0/0", pc, fv, pend); end
      checks++; if (pcp !== 32'h4 || reg4 !== 4'h0) begin failures++; $display("FAIL reset_derived pc_plus=%h region=%h want 4/0", pcp, reg4); end
      @(posedge clk); #1; rst_n = 1; ready = 1;
      checks++; if (fv !== 1'b0) begin failures++; $display("FAIL boot_cycle fv=%b want 0", fv); end
      tick();
      checks++; if (fv !== 1'b1 || pc !== 32'h0) begin failures++; $display("FAIL first_fetch fv=%b pc=%h want 1/0", fv, pc); end
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (pc !== 32'(i * 4) || pcp !== 32'(i * 4 + 4)) begin failures++; $display("FAIL seq_%0d pc=%h plus=%h want %h/%h", i, pc, pcp, i * 4, i * 4 + 4); end
      end
   endtask

   task automatic test_stall();
      tick();
      checks++; if (pc !== 32'h10) begin failures++; $display("FAIL reach_10 pc=%h want 10", pc); end
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (pc !== 32'h10) begin failures++; $display("FAIL stall_hold pc=%h want 10", pc); end
      end
      stall = 0; ready = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (pc !== 32'h10 || fv !== 1'b1) begin failures++; $display("FAIL backpressure_hold pc=%h fv=%b want 10/1", pc, fv); end
      end
      ready = 1; tick();
      checks++; if (pc !== 32'h14) begin failures++; $display("FAIL resume pc=%h want 14", pc); end
   endtask

   task automatic test_redirect();
      rv = 1; rpc = 32'h400; tick();
      checks++; if (pc !== 32'h400 || reg4 !== 4'h0) begin failures++; $display("FAIL redirect pc=%h region=%h want 400/0", pc, reg4); end
      rpc = 32'h403; tick();
      checks++; if (pc !== 32'h400) begin failures++; $display("FAIL align pc=%h want 400", pc); end
      rpc = 32'hA000_0000; tick();
      checks++; if (pc !== 32'hA000_0000 || reg4 !== 4'hA) begin failures++; $display("FAIL region pc=%h region=%h want a0000000/a", pc, reg4); end
      rv = 0;
   endtask

   task automatic test_pending();
      stall = 1; rv = 1; rpc = 32'h200; tick();
      rpc = 32'h300; tick();
      checks++; if (pend !== 1'b1 || pc !== 32'hA000_0000) begin failures++; $display("FAIL pending_set pend=%b pc=%h want 1/a0000000", pend, pc); end
      rv = 0; stall = 0; tick();
      checks++; if (pc !== 32'h300 || pend !== 1'b0) begin failures++; $display("FAIL pending_apply pc=%h pend=%b want 300/0", pc, pend); end
   endtask

   task automatic test_trap_reset();
      stall = 1; rv = 1; rpc = 32'h500; tick();
      checks++; if (pend !== 1'b1) begin failures++; $display("FAIL trap_pre pend=%b want 1", pend); end
      rv = 0; trap = 1; tick();
      checks++; if (pc !== 32'h180 || pend !== 1'b0) begin failures++; $display("FAIL trap pc=%h pend=%b want 180/0", pc, pend); end
      trap = 0; rv = 1; rpc = 32'h600; tick();
      checks++; if (pc !== 32'h180 || pend !== 1'b1) begin failures++; $display("FAIL trap_hold pc=%h pend=%b want 180/1", pc, pend); end
      rv = 0; #2; rst_n = 0; model_reset(); #1;
      checks++; if (pc !== 32'h0 || pend !== 1'b0 || fv !== 1'b0) begin failures++; $display("FAIL async_reset pc=%h pend=%b fv=%b want 0/0/0", pc, pend, fv); end
      @(posedge clk); #1; rst_n = 1; stall = 0; ready = 1;
      tick();
      checks++; if (pc !== 32'h0 || fv !== 1'b1 || pend !== 1'b0) begin failures++; $display("FAIL reboot pc=%h fv=%b pend=%b want 0/1/0", pc, fv, pend); end
   endtask

   task automatic test_wrap();
      stall = 0; ready = 1; rv = 0; trap = 0;
      rst_n = 0; model_reset(); #1;
      checks++; if (w_pc !== 8'hF8 || w_fv !== 1'b0) begin failures++; $display("FAIL wrap_reset pc=%h fv=%b want f8/0", w_pc, w_fv); end
      @(posedge clk); #1; rst_n = 1;
      tick();
      checks++; if (w_pc !== 8'hF8 || w_fv !== 1'b1 || w_reg !== 4'hF) begin failures++; $display("FAIL wrap_f8 pc=%h fv=%b region=%h want f8/1/f", w_pc, w_fv, w_reg); end
      tick();
      checks++; if (w_pc !== 8'hFC || w_pcp !== 8'h00) begin failures++; $display("FAIL wrap_fc pc=%h plus=%h want fc/00", w_pc, w_pcp); end
      tick();
      checks++; if (w_pc !== 8'h00 || w_pend !== 1'b0) begin failures++; $display("FAIL wrap_00 pc=%h pend=%b want 00/0", w_pc, w_pend); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         stall = ($urandom_range(3) == 0);
         ready = ($urandom_range(3) != 0);
         rv    = ($urandom_range(9) < 3);
         trap  = ($urandom_range(19) == 0);
         rpc   = $urandom;
         tick();
         checks++;
         if (pc !== m_pc || fv !== 1'b1 || pend !== m_pend || pcp !== m_pc + 32'd4 || reg4 !== m_pc[31:28]) begin
            failures++;
            $display("FAIL random_%0d pc=%h fv=%b pend=%b plus=%h region=%h want pc=%h pend=%b", i, pc, fv, pend, pcp, reg4, m_pc, m_pend);
         end
      end
      stall = 0; ready = 1; rv = 0; trap = 0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_pending();
      test_trap_reset();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
